mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences the PC register, PC mux, PC+4 adder, shared memory, register file and the 2-bit-aluop ALU through fetch/decode/execute/writeback phases for lw, sw, R-type, beq, addi and j. A mem_ready handshake stalls it on memory accesses. It also counts retired instructions.

Parameters:
COUNT_W, 32, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode returns to FETCH

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pcen  out  1  PC register enable = pcwrite | (branch & zero)
iord  out  1  memory address select: 0 PC, 1 ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  register-file write address: 0 rt, 1 rd
memtoreg  out  1  register-file write data: 0 ALUOut, 1 MDR
regwrite  out  1  register-file write strobe
alusrca  out  1  ALU A: 0 PC, 1 regA
alusrcb  out  2  ALU B: 00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
aluop  out  2  00 add, 01 sub, 10 decode funct
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
illegal  out  1  one-cycle pulse on unsupported opcode in DECODE
halted  out  1  FSM in HALT
instr_count  out  COUNT_W  retired instructions

Behaviour:
- Reset: synchronous, active-high. State goes to FETCH and instr_count to 0. While reset=1, every strobe (pcen, irwrite, memwrite, regwrite, illegal) is forced to 0. Mux selects are don't-care but drive 0.
- Outputs are Moore (decoded from state). Exceptions: mem_ready gating and pcen, which are combinational.
- Unlisted outputs are 0 in each state.
- FETCH: alusrcb=01, aluop=00, pcsrc=00, iord=0. irwrite=pcwrite=mem_ready. Hold while mem_ready=0, else go to DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - 100011 or 101011: MEMADR
  - 000000: EXECUTE
  - 000100: BRANCH
  - 001000: ADDIEX
  - 000010: JUMP
  - other: illegal=1, then HALT if TRAP_ON_ILLEGAL, else FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD if opcode=100011, else MEMWR. Opcode is sampled from the IR, which is stable after FETCH.
- MEMRD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1, held every cycle until mem_ready. Go to FETCH on the mem_ready cycle.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regdst=1, regwrite=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, so pcen=zero. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regdst=0, regwrite=1. Go to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- HALT: all strobes 0, halted=1. Absorbing; only reset exits.
- instr_count increments by 1 on each transition from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP into FETCH. It wraps modulo 2^COUNT_W. Illegal opcodes do not count.
- Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset mid-instruction aborts it: no count increment, and no strobe is asserted in the reset cycle.
- Reset has priority over mem_ready and over every other input.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOP_ADD/SUB/FUNCT, ALUSRCB_*, PCSRC_* encodings
- One sub-module, mips_ctrl_outdec: purely combinational state-to-control decode. The FSM module keeps the state register, next-state logic, mem_ready gating, pcen and the counter.

Test Plan:
- Reset held 2 cycles mid-EXECUTE, then released -> first cycle FETCH with irwrite=pcwrite=1; instr_count=0; no regwrite while reset=1.
- lw (100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 on cycle 5; instr_count 0->1.
- sw (101011), mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, iord=1; FETCH follows; count +1.
- beq (000100) with zero=1 -> pcen=1, pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0; each takes 3 cycles.
- R-type (000000) then addi (001000) then j (000010) -> aluop=10 in EXECUTE and regdst=1 in ALUWB; regdst=0 in ADDIWB; pcsrc=10 and pcen=1 in JUMP; instr_count=3.
- opcode 111111 with TRAP_ON_ILLEGAL=1 -> illegal pulses 1 cycle in DECODE; halted=1 thereafter with all strobes 0; instr_count unchanged. With TRAP_ON_ILLEGAL=0 -> next state FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Opcodes, state enum, datapath select codes and the decoded control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       halted;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore decode of controller state into raw datapath controls.
// FETCH irwrite is raw here; the FSM gates it with mem_ready.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_REGB;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ADDIWB: ctrl.regwrite = 1'b1;
            JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath with mem_ready
// stalls and a retired-instruction counter.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W         = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               illegal,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    ctrl_t              ctrl;
    logic               retire;
    logic               run;
    logic               pcwrite;

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = TRAP_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        count_d = count_q + COUNT_W'(retire);
        if (reset) begin
            state_d = FETCH;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        count_q <= count_d;
    end

    // Reset blanks every output, including the combinational strobes.
    assign run     = ~reset;
    assign pcwrite = ctrl.pcwrite | (ctrl.irwrite & mem_ready);

    assign pcen     = run & (pcwrite | (ctrl.branch & zero));
    assign irwrite  = run & ctrl.irwrite & mem_ready;
    assign memwrite = run & ctrl.memwrite;
    assign regwrite = run & ctrl.regwrite;
    assign illegal  = run & (state_q == DECODE) & ~op_legal(opcode);
    assign iord     = run & ctrl.iord;
    assign regdst   = run & ctrl.regdst;
    assign memtoreg = run & ctrl.memtoreg;
    assign alusrca  = run & ctrl.alusrca;
    assign alusrcb  = run ? ctrl.alusrcb : 2'b00;
    assign aluop    = run ? ctrl.aluop : 2'b00;
    assign pcsrc    = run ? ctrl.pcsrc : 2'b00;
    assign halted   = run & ctrl.halted;

    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: instruction table,
// reset/illegal sequences and a random run against a schedule model.
module tb_mips_multicycle_controller;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;

    logic        pcen, iord, memwrite, irwrite, regdst, memtoreg;
    logic        regwrite, alusrca, illegal, halted;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic [31:0] instr_count;

    logic        n_pcen, n_iord, n_memwrite, n_irwrite, n_regdst;
    logic        n_memtoreg, n_regwrite, n_alusrca, n_illegal, n_halted;
    logic [1:0]  n_alusrcb, n_aluop, n_pcsrc;
    logic [31:0] n_instr_count;

    int errs = 0;
    int checks = 0;
    int exp_cnt = 0;

    mips_multicycle_controller #(.COUNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .illegal(illegal), .halted(halted), .instr_count(instr_count)
    );

    mips_multicycle_controller #(.COUNT_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pcen(n_pcen), .iord(n_iord),
        .memwrite(n_memwrite), .irwrite(n_irwrite), .regdst(n_regdst),
        .memtoreg(n_memtoreg), .regwrite(n_regwrite), .alusrca(n_alusrca),
        .alusrcb(n_alusrcb), .aluop(n_aluop), .pcsrc(n_pcsrc),
        .illegal(n_illegal), .halted(n_halted), .instr_count(n_instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Holds reset over n edges, then checks the first FETCH cycle.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("rst_strobes", {59'd0, pcen, irwrite, memwrite, regwrite,
                illegal}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_fetch", {55'd0, irwrite, pcen, iord, alusrcb, aluop, pcsrc},
            {55'd0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00});
        chk("rst_count", {32'd0, instr_count}, 64'd0);
        mem_ready = 1'b0;
        #1;
        chk("fetch_stall", {62'd0, irwrite, pcen}, 64'd0);
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fst;
        int         mst;
        int         cyc;
        int         regw;
        int         memw;
        int         pcenc;
        logic       rd;
        logic       mtr;
        logic [1:0] pcs;
        logic       fn;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int cyc = 0, regw = 0, memw = 0, pc = 0;
        int fst = v.fst, mst = v.mst;
        logic rd = 1'b0, mtr = 1'b0, fn = 1'b0, done = 1'b0;
        logic [1:0] pcs = 2'b00;
        logic [31:0] prev;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            opcode = v.op; zero = v.z;
            if (fst > 0) begin
                mem_ready = 1'b0; fst--;
            end else if (iord && mst > 0) begin
                mem_ready = 1'b0; mst--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            cyc++;
            if (regwrite) begin regw++; rd = regdst; mtr = memtoreg; end
            if (memwrite) memw++;
            if (pcen) pc++;
            if (aluop == ALUOP_FUNCT) fn = 1'b1;
            pcs = pcsrc;
            prev = instr_count;
            @(posedge clk);
            #1;
            if (instr_count != prev) begin done = 1'b1; break; end
        end
        exp_cnt++;
        chk($sformatf("op%02h_retired", v.op), {63'd0, done}, 64'd1);
        chk($sformatf("op%02h_cycles", v.op), 64'(cyc), 64'(v.cyc));
        chk($sformatf("op%02h_strobes", v.op), {32'd0, 8'(regw), 8'(memw),
            8'(pc), 8'd0}, {32'd0, 8'(v.regw), 8'(v.memw), 8'(v.pcenc), 8'd0});
        chk($sformatf("op%02h_sel", v.op), {59'd0, rd, mtr, pcs, fn},
            {59'd0, v.rd, v.mtr, v.pcs, v.fn});
        chk($sformatf("op%02h_count", v.op), {32'd0, instr_count},
            64'(exp_cnt));
    endtask

    // Schedule model: each instruction is a list of phases; phases that
    // touch memory wait for mem_ready.
    localparam int K_F = 0, K_P = 1, K_MR = 2, K_WB = 3, K_ST = 4,
                   K_BR = 5, K_JMP = 6;

    function automatic int slen(input logic [5:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_BEQ || op == OP_J) return 3;
        return 4;
    endfunction

    function automatic int kind(input logic [5:0] op, input int idx);
        if (idx == 0) return K_F;
        if (op == OP_LW && idx == 3) return K_MR;
        if (idx == slen(op) - 1) begin
            if (op == OP_SW) return K_ST;
            if (op == OP_BEQ) return K_BR;
            if (op == OP_J) return K_JMP;
            return K_WB;
        end
        return K_P;
    endfunction

    vec_t vecs[9];
    logic [5:0] ops[6];

    initial begin
        vecs[0] = '{OP_LW,    1'b0, 0, 0, 5, 1, 0, 1, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[1] = '{OP_SW,    1'b0, 0, 3, 7, 0, 4, 1, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{OP_BEQ,   1'b1, 0, 0, 3, 0, 0, 2, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[3] = '{OP_BEQ,   1'b0, 0, 0, 3, 0, 0, 1, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[4] = '{OP_RTYPE, 1'b0, 0, 0, 4, 1, 0, 1, 1'b1, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{OP_ADDI,  1'b1, 0, 0, 4, 1, 0, 1, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{OP_J,     1'b0, 0, 0, 3, 0, 0, 2, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[7] = '{OP_LW,    1'b1, 2, 2, 9, 1, 0, 1, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[8] = '{OP_SW,    1'b1, 1, 0, 5, 0, 1, 1, 1'b0, 1'b0, 2'b00, 1'b0};
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

        do_reset(2);
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Abort an R-type in EXECUTE with a two-cycle reset.
        @(negedge clk);
        opcode = OP_RTYPE; mem_ready = 1'b1;
        @(negedge clk);
        do_reset(2);

        // Illegal opcode: trap variant halts, other variant refetches.
        @(negedge clk);
        opcode = 6'b111111; mem_ready = 1'b1; zero = 1'b1;
        #1;
        chk("ill_fetch", {63'd0, irwrite}, 64'd1);
        @(negedge clk);
        #1;
        chk("ill_pulse", {61'd0, illegal, n_illegal, pcen}, {61'd0, 3'b110});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = ops[$urandom_range(0, 5)];
            mem_ready = 1'b1; zero = 1'b1;
            #1;
            chk("halt_state", {57'd0, halted, illegal, pcen, irwrite,
                memwrite, regwrite, iord}, {57'd0, 7'b1000000});
            chk("halt_count", {32'd0, instr_count}, 64'd0);
            if (i == 0)
                chk("notrap_fetch", {62'd0, n_halted, n_irwrite}, 64'd1);
        end

        // Random instruction stream against the schedule model.
        do_reset(1);
        begin
            int idx = 0, cnt = 0, k;
            logic fresh = 1'b1;
            logic [5:0] op = OP_RTYPE;
            logic [36:0] expv;
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                if (idx == 0 && fresh) begin
                    op = ops[$urandom_range(0, 5)];
                    fresh = 1'b0;
                end
                opcode = op;
                zero = 1'($urandom_range(0, 1));
                mem_ready = ($urandom_range(0, 3) != 0);
                k = kind(op, idx);
                expv = {(k == K_F) & mem_ready, k == K_ST, k == K_WB,
                        ((k == K_F) & mem_ready) | ((k == K_BR) & zero)
                        | (k == K_JMP), 1'b0, 32'(cnt)};
                #1;
                chk($sformatf("rand_c%0d", c), {27'd0, irwrite, memwrite,
                    regwrite, pcen, illegal, instr_count}, {27'd0, expv});
                if (!((k == K_F || k == K_MR || k == K_ST) && !mem_ready)) begin
                    idx++;
                    if (idx == slen(op)) begin
                        idx = 0; cnt++; fresh = 1'b1;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
